// File: rtl/shift_sequencer_if.sv
// Request, shifter and result bundle for shift_sequencer.
// master = requesters + shifter array, slave = sequencer.
interface shift_sequencer_if #(
  parameter int SWR = 26,
  parameter int EW  = 5
);
  logic           flush_i;
  logic           align_req_i;
  logic [SWR-1:0] align_data_i;
  logic [EW-1:0]  align_amt_i;
  logic           align_fill_i;
  logic           align_gnt_o;
  logic           norm_req_i;
  logic [SWR-1:0] norm_data_i;
  logic [EW-1:0]  norm_amt_i;
  logic           norm_fill_i;
  logic           norm_gnt_o;
  logic [SWR-1:0] sh_data_o;
  logic           sh_dir_o;
  logic [EW-1:0]  sh_amt_o;
  logic           sh_fill_o;
  logic [SWR-1:0] sh_data_i;
  logic           busy_o;
  logic           res_valid_o;
  logic [SWR-1:0] res_data_o;
  logic           res_owner_o;

  modport master (
    output flush_i,
    output align_req_i, align_data_i,
    output align_amt_i, align_fill_i,
    input  align_gnt_o,
    output norm_req_i, norm_data_i,
    output norm_amt_i, norm_fill_i,
    input  norm_gnt_o,
    input  sh_data_o, sh_dir_o,
    input  sh_amt_o, sh_fill_o,
    output sh_data_i,
    input  busy_o, res_valid_o,
    input  res_data_o, res_owner_o
  );

  modport slave (
    input  flush_i,
    input  align_req_i, align_data_i,
    input  align_amt_i, align_fill_i,
    output align_gnt_o,
    input  norm_req_i, norm_data_i,
    input  norm_amt_i, norm_fill_i,
    output norm_gnt_o,
    output sh_data_o, sh_dir_o,
    output sh_amt_o, sh_fill_o,
    input  sh_data_i,
    output busy_o, res_valid_o,
    output res_data_o, res_owner_o
  );
endinterface

// File: rtl/shift_sequencer.sv
// Shares one barrel shifter between alignment and normalization.
// SHIFT_SEQ_RR_EN: round-robin arbitration instead of norm-first.
module shift_sequencer #(
  parameter int SWR = 26,
  parameter int EW  = 5
) (
  input  logic clk,
  input  logic rst,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, LOAD, CAPT, DONE
  } state_t;

  state_t        state;
  logic          owner;
  logic          sat;
  logic          idle_ok;
  logic          pick_n;
  logic          pick_a;
  logic          any_gnt;
  logic [EW-1:0] amt_sel;
  logic          sat_d;

  // Grants only from IDLE, out of reset and not flushed.
  assign idle_ok = rst & (state == IDLE)
                 & ~bus.flush_i;

`ifdef SHIFT_SEQ_RR_EN
  logic ptr;

  // Last owner wins nothing on a tie; the other side goes.
  assign pick_n = bus.norm_req_i
                & (~bus.align_req_i | ~ptr);

  // Pointer remembers the owner of the latest grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= 1'b0;
    else if (any_gnt)
      ptr <= pick_n;
  end
`else
  assign pick_n = bus.norm_req_i;
`endif

  assign pick_a = bus.align_req_i & ~pick_n;
  assign bus.norm_gnt_o  = idle_ok & pick_n;
  assign bus.align_gnt_o = idle_ok & pick_a;
  assign any_gnt = bus.norm_gnt_o
                 | bus.align_gnt_o;

  assign amt_sel = pick_n ? bus.norm_amt_i
                          : bus.align_amt_i;
  // Amounts past the data width flush out every bit.
  assign sat_d = 32'(amt_sel) >= SWR;

  // Sequencer FSM with registered shifter and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      sat             <= 1'b0;
      bus.sh_data_o   <= '0;
      bus.sh_dir_o    <= 1'b0;
      bus.sh_amt_o    <= '0;
      bus.sh_fill_o   <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.res_valid_o <= 1'b0;
      bus.res_data_o  <= '0;
      bus.res_owner_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_gnt) begin
            bus.sh_data_o <= pick_n ? bus.norm_data_i
                                    : bus.align_data_i;
            bus.sh_fill_o <= pick_n ? bus.norm_fill_i
                                    : bus.align_fill_i;
            bus.sh_amt_o  <= amt_sel;
            bus.sh_dir_o  <= pick_n;
            owner         <= pick_n;
            sat           <= sat_d;
            bus.busy_o    <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (bus.flush_i) begin
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end else begin
            state      <= CAPT;
          end
        end
        CAPT: begin
          if (bus.flush_i) begin
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end else begin
            bus.res_data_o  <= sat ? {SWR{bus.sh_fill_o}}
                                   : bus.sh_data_i;
            bus.res_owner_o <= owner;
            bus.res_valid_o <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.res_valid_o <= 1'b0;
          bus.busy_o      <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural
// barrel shifter driving sh_data_i.
module tb_shift_sequencer;

  localparam int SWR = 26;
  localparam int EW  = 5;

`ifdef SHIFT_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  logic corrupt;
  int   passed;
  int   total;

  shift_sequencer_if #(.SWR(SWR), .EW(EW)) bus ();

  shift_sequencer #(.SWR(SWR), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SWR-1:0] ones;
  assign ones = '1;

  // Reference barrel shifter; corrupt forces junk output.
  always_comb begin
    bus.sh_data_i = '0;
    if (corrupt)
      bus.sh_data_i = 26'h0A5A5A5;
    else if (bus.sh_dir_o)
      bus.sh_data_i = (bus.sh_data_o << bus.sh_amt_o)
        | (bus.sh_fill_o ? ~(ones << bus.sh_amt_o) : '0);
    else
      bus.sh_data_i = (bus.sh_data_o >> bus.sh_amt_o)
        | (bus.sh_fill_o ? ~(ones >> bus.sh_amt_o) : '0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush_i      = 1'b0;
    bus.align_req_i  = 1'b0;
    bus.align_data_i = '0;
    bus.align_amt_i  = '0;
    bus.align_fill_i = 1'b0;
    bus.norm_req_i   = 1'b0;
    bus.norm_data_i  = '0;
    bus.norm_amt_i   = '0;
    bus.norm_fill_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    corrupt = 1'b0;
    idle_inputs();
    bus.align_req_i = 1'b1;
    #3;
    total++;
    if (bus.align_gnt_o !== 1'b0)
      $display("FAIL rst_gnt got %b exp 0",
               bus.align_gnt_o);
    else passed++;
    total++;
    if ({bus.busy_o, bus.res_valid_o,
         bus.res_owner_o, bus.sh_dir_o} !== 4'b0)
      $display("FAIL rst_flags got %b exp 0000",
               {bus.busy_o, bus.res_valid_o,
                bus.res_owner_o, bus.sh_dir_o});
    else passed++;
    total++;
    if (bus.res_data_o !== 26'h0)
      $display("FAIL rst_res got %h exp 0",
               bus.res_data_o);
    else passed++;
    bus.align_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_align;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h3FFFFFF;
    bus.align_amt_i  = 5'd4;
    bus.align_fill_i = 1'b0;
    #1;
    total++;
    if ({bus.align_gnt_o, bus.norm_gnt_o} !== 2'b10)
      $display("FAIL align_gnt got %b exp 10",
               {bus.align_gnt_o, bus.norm_gnt_o});
    else passed++;
    tick();
    bus.align_req_i = 1'b0;
    total++;
    if ({bus.busy_o, bus.sh_dir_o, bus.sh_amt_o}
        !== {1'b1, 1'b0, 5'd4})
      $display("FAIL align_load got %b exp 1000100",
               {bus.busy_o, bus.sh_dir_o, bus.sh_amt_o});
    else passed++;
    tick();
    total++;
    if (bus.res_valid_o !== 1'b0)
      $display("FAIL align_early got %b exp 0",
               bus.res_valid_o);
    else passed++;
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_owner_o,
         bus.res_data_o} !== {2'b10, 26'h03FFFFF})
      $display("FAIL align_res got %b %h exp 10 03fffff",
               {bus.res_valid_o, bus.res_owner_o},
               bus.res_data_o);
    else passed++;
    tick();
    total++;
    if ({bus.res_valid_o, bus.busy_o} !== 2'b00)
      $display("FAIL align_end got %b exp 00",
               {bus.res_valid_o, bus.busy_o});
    else passed++;
  endtask

  task automatic test_norm;
    bus.norm_req_i  = 1'b1;
    bus.norm_data_i = 26'h0000001;
    bus.norm_amt_i  = 5'd25;
    bus.norm_fill_i = 1'b0;
    #1;
    total++;
    if ({bus.align_gnt_o, bus.norm_gnt_o} !== 2'b01)
      $display("FAIL norm_gnt got %b exp 01",
               {bus.align_gnt_o, bus.norm_gnt_o});
    else passed++;
    tick();
    bus.norm_req_i = 1'b0;
    total++;
    if (bus.sh_dir_o !== 1'b1)
      $display("FAIL norm_dir got %b exp 1",
               bus.sh_dir_o);
    else passed++;
    tick();
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_owner_o,
         bus.res_data_o} !== {2'b11, 26'h2000000})
      $display("FAIL norm_res got %b %h exp 11 2000000",
               {bus.res_valid_o, bus.res_owner_o},
               bus.res_data_o);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic fo;
    logic [SWR-1:0] r1;
    logic [SWR-1:0] r2;
    fo = ~RR;
    r1 = fo ? 26'h2000000 : 26'h03FFFFF;
    r2 = fo ? 26'h03FFFFF : 26'h2000000;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h3FFFFFF;
    bus.align_amt_i  = 5'd4;
    bus.align_fill_i = 1'b0;
    bus.norm_req_i   = 1'b1;
    bus.norm_data_i  = 26'h0000001;
    bus.norm_amt_i   = 5'd25;
    bus.norm_fill_i  = 1'b0;
    #1;
    total++;
    if ({bus.align_gnt_o, bus.norm_gnt_o} !== {~fo, fo})
      $display("FAIL b2b_first got %b exp %b",
               {bus.align_gnt_o, bus.norm_gnt_o},
               {~fo, fo});
    else passed++;
    tick();
    if (fo) bus.norm_req_i = 1'b0;
    else bus.align_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.align_gnt_o, bus.norm_gnt_o} !== 2'b00)
        $display("FAIL b2b_busy_gnt cyc %0d got %b exp 00",
                 i, {bus.align_gnt_o, bus.norm_gnt_o});
      else passed++;
      if (i < 2) tick();
    end
    total++;
    if ({bus.res_valid_o, bus.res_owner_o,
         bus.res_data_o} !== {1'b1, fo, r1})
      $display("FAIL b2b_res1 got %b %h exp %b %h",
               {bus.res_valid_o, bus.res_owner_o},
               bus.res_data_o, {1'b1, fo}, r1);
    else passed++;
    tick();
    total++;
    if ({bus.align_gnt_o, bus.norm_gnt_o} !== {fo, ~fo})
      $display("FAIL b2b_second got %b exp %b",
               {bus.align_gnt_o, bus.norm_gnt_o},
               {fo, ~fo});
    else passed++;
    tick();
    bus.align_req_i = 1'b0;
    bus.norm_req_i  = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_owner_o,
         bus.res_data_o} !== {1'b1, ~fo, r2})
      $display("FAIL b2b_res2 got %b %h exp %b %h",
               {bus.res_valid_o, bus.res_owner_o},
               bus.res_data_o, {1'b1, ~fo}, r2);
    else passed++;
    tick();
  endtask

  task automatic test_saturation;
    corrupt = 1'b1;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h1234567;
    bus.align_amt_i  = 5'd30;
    bus.align_fill_i = 1'b1;
    tick();
    bus.align_req_i = 1'b0;
    tick();
    tick();
    total++;
    if (bus.res_data_o !== 26'h3FFFFFF)
      $display("FAIL sat30 got %h exp 3ffffff",
               bus.res_data_o);
    else passed++;
    tick();
    corrupt = 1'b0;
    bus.norm_req_i  = 1'b1;
    bus.norm_data_i = 26'h1234567;
    bus.norm_amt_i  = 5'd0;
    bus.norm_fill_i = 1'b1;
    tick();
    bus.norm_req_i = 1'b0;
    tick();
    tick();
    total++;
    if (bus.res_data_o !== 26'h1234567)
      $display("FAIL amt0 got %h exp 1234567",
               bus.res_data_o);
    else passed++;
    tick();
    corrupt = 1'b1;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h3FFFFFF;
    bus.align_amt_i  = 5'd26;
    bus.align_fill_i = 1'b0;
    tick();
    bus.align_req_i = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_data_o}
        !== {1'b1, 26'h0})
      $display("FAIL sat26 got %b %h exp 1 0",
               bus.res_valid_o, bus.res_data_o);
    else passed++;
    tick();
    corrupt = 1'b0;
  endtask

  task automatic test_flush;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h0000F0F;
    bus.align_amt_i  = 5'd4;
    bus.align_fill_i = 1'b0;
    tick();
    tick();
    bus.flush_i = 1'b1;
    tick();
    total++;
    if ({bus.res_valid_o, bus.busy_o} !== 2'b00)
      $display("FAIL flush_state got %b exp 00",
               {bus.res_valid_o, bus.busy_o});
    else passed++;
    total++;
    if (bus.res_data_o !== 26'h0)
      $display("FAIL flush_res got %h exp 0",
               bus.res_data_o);
    else passed++;
    total++;
    if (bus.align_gnt_o !== 1'b0)
      $display("FAIL flush_idle_gnt got %b exp 0",
               bus.align_gnt_o);
    else passed++;
    bus.flush_i = 1'b0;
    #1;
    total++;
    if (bus.align_gnt_o !== 1'b1)
      $display("FAIL flush_regnt got %b exp 1",
               bus.align_gnt_o);
    else passed++;
    tick();
    bus.align_req_i = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_data_o}
        !== {1'b1, 26'h00000F0})
      $display("FAIL flush_after got %b %h exp 1 00000f0",
               bus.res_valid_o, bus.res_data_o);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid;
    bus.align_req_i  = 1'b1;
    bus.align_data_i = 26'h3FFFFFF;
    bus.align_amt_i  = 5'd4;
    bus.align_fill_i = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.sh_data_o, bus.sh_amt_o, bus.sh_fill_o}
        !== '0)
      $display("FAIL rmid_sh got %h %h exp 0 0",
               bus.sh_data_o, bus.sh_amt_o);
    else passed++;
    total++;
    if ({bus.busy_o, bus.res_valid_o, bus.res_owner_o,
         bus.align_gnt_o} !== 4'b0)
      $display("FAIL rmid_flags got %b exp 0000",
               {bus.busy_o, bus.res_valid_o,
                bus.res_owner_o, bus.align_gnt_o});
    else passed++;
    total++;
    if (bus.res_data_o !== 26'h0)
      $display("FAIL rmid_res got %h exp 0",
               bus.res_data_o);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.align_gnt_o !== 1'b1)
      $display("FAIL rmid_regnt got %b exp 1",
               bus.align_gnt_o);
    else passed++;
    tick();
    bus.align_req_i = 1'b0;
    total++;
    if ({bus.busy_o, bus.sh_data_o}
        !== {1'b1, 26'h3FFFFFF})
      $display("FAIL rmid_load got %b %h exp 1 3ffffff",
               bus.busy_o, bus.sh_data_o);
    else passed++;
    tick();
    tick();
    total++;
    if ({bus.res_valid_o, bus.res_data_o}
        !== {1'b1, 26'h3FFFFFF})
      $display("FAIL rmid_res2 got %b %h exp 1 3ffffff",
               bus.res_valid_o, bus.res_data_o);
    else passed++;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_align();
    test_norm();
    test_back_to_back();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
